// File: rtl/stepper_pkg.sv
// Shared types and default constants for the step/direction axis and its command decoder.
package stepper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    DONE
  } state_t;

  localparam int DEF_POS_W         = 24;
  localparam int DEF_PERIOD_W      = 21;
  localparam int DEF_START_PERIOD  = 800_000;
  localparam int DEF_ACCEL_DEC     = 5_000;
  localparam int DEF_PULSE_CYC     = 10;
  localparam int DEF_DIR_SETUP_CYC = 4;

endpackage

// File: rtl/stepper_axis_if.sv
// Valid/ready move-command channel from the command decoder to one stepper axis.
import stepper_pkg::*;

interface stepper_axis_if #(
  parameter int POS_W    = DEF_POS_W,
  parameter int PERIOD_W = DEF_PERIOD_W
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [POS_W-1:0]    cmd_goal;
  logic [PERIOD_W-1:0] cmd_period;

  modport master (output cmd_valid, cmd_goal, cmd_period, input cmd_ready);
  modport slave  (input cmd_valid, cmd_goal, cmd_period, output cmd_ready);
endinterface

// File: rtl/stepper_ramp.sv
// Trapezoidal ramp rule: period and accel-step count for the interval after a step.
module stepper_ramp #(
  parameter int POS_W        = 24,
  parameter int PERIOD_W     = 21,
  parameter int START_PERIOD = 800_000,
  parameter int ACCEL_DEC    = 5_000
) (
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] target,
  input  logic [POS_W-1:0]    n,
  input  logic [POS_W-1:0]    r,
  output logic [PERIOD_W-1:0] next_period,
  output logic [POS_W-1:0]    next_n
);
  localparam logic [PERIOD_W:0] START_EXT = (PERIOD_W+1)'(START_PERIOD);
  localparam logic [PERIOD_W:0] DEC_EXT   = (PERIOD_W+1)'(ACCEL_DEC);

  // One extra bit so the sum and gap can be compared without wrapping.
  logic [PERIOD_W:0] sum;
  logic [PERIOD_W:0] gap;

  always_comb begin
    sum         = {1'b0, period} + DEC_EXT;
    gap         = {1'b0, period} - {1'b0, target};
    next_period = period;
    next_n      = n;
    if (r <= n) begin
      next_period = (sum > START_EXT) ? START_EXT[PERIOD_W-1:0] : sum[PERIOD_W-1:0];
      if (n != '0) next_n = n - POS_W'(1);
    end else if (period > target) begin
      next_period = (gap > DEC_EXT) ? period - DEC_EXT[PERIOD_W-1:0] : target;
      next_n      = n + POS_W'(1);
    end
  end
endmodule

// File: rtl/stepper_axis.sv
// Single-axis step/direction generator with trapezoidal ramp, dir setup and abort.
import stepper_pkg::*;

module stepper_axis #(
  parameter int POS_W         = DEF_POS_W,
  parameter int PERIOD_W      = DEF_PERIOD_W,
  parameter int START_PERIOD  = DEF_START_PERIOD,
  parameter int ACCEL_DEC     = DEF_ACCEL_DEC,
  parameter int PULSE_CYC     = DEF_PULSE_CYC,
  parameter int DIR_SETUP_CYC = DEF_DIR_SETUP_CYC
) (
  input  logic             clk,
  input  logic             reset,
  stepper_axis_if.slave    cmd,
  input  logic             abort,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] position
);
  localparam logic [PERIOD_W-1:0] START_P    = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(PULSE_CYC + 1);
  localparam logic [PERIOD_W-1:0] PULSE_LAST = PERIOD_W'(PULSE_CYC - 1);
  localparam logic [PERIOD_W-1:0] SETUP_LAST = PERIOD_W'(DIR_SETUP_CYC - 1);

  state_t              state;
  logic                cmd_ready_q;
  logic                abort_pend;
  logic [POS_W-1:0]    goal;
  logic [POS_W-1:0]    n;
  logic [PERIOD_W-1:0] target;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] cnt;

  logic [PERIOD_W-1:0] tgt_clamp;
  logic [POS_W-1:0]    pos_next;
  logic [POS_W-1:0]    r_after;
  logic [PERIOD_W-1:0] ramp_period;
  logic [POS_W-1:0]    ramp_n;
  logic                interval_end;
  logic                launch;

  assign cmd.cmd_ready = cmd_ready_q;
  assign tgt_clamp     = (cmd.cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd.cmd_period;

  // Position and remaining distance as they will be once the next step rises.
  assign pos_next     = dir ? position - POS_W'(1) : position + POS_W'(1);
  assign r_after      = dir ? pos_next - goal : goal - pos_next;
  assign interval_end = (cnt == period - PERIOD_W'(1));
  assign launch       = !abort &&
                        ((state == SETUP && cnt == SETUP_LAST) ||
                         (state == LOW && interval_end && position != goal));

  stepper_ramp #(
    .POS_W       (POS_W),
    .PERIOD_W    (PERIOD_W),
    .START_PERIOD(START_PERIOD),
    .ACCEL_DEC   (ACCEL_DEC)
  ) u_ramp (
    .period     (period),
    .target     (target),
    .n          (n),
    .r          (r_after),
    .next_period(ramp_period),
    .next_n     (ramp_n)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      abort_pend  <= 1'b0;
      goal        <= '0;
      n           <= '0;
      target      <= '0;
      period      <= '0;
      cnt         <= '0;
      step        <= 1'b0;
      dir         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      position    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            goal        <= cmd.cmd_goal;
            target      <= tgt_clamp;
            if (cmd.cmd_goal == position) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= SETUP;
              busy       <= 1'b1;
              dir        <= (cmd.cmd_goal < position);
              period     <= (tgt_clamp > START_P) ? tgt_clamp : START_P;
              n          <= '0;
              cnt        <= '0;
              abort_pend <= 1'b0;
            end
          end
        end
        SETUP: begin
          cnt <= cnt + PERIOD_W'(1);
          if (abort) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        HIGH: begin
          cnt        <= cnt + PERIOD_W'(1);
          abort_pend <= abort_pend | abort;
          if (cnt == PULSE_LAST) begin
            step <= 1'b0;
            if (abort_pend || abort) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= LOW;
            end
          end
        end
        LOW: begin
          cnt <= cnt + PERIOD_W'(1);
          if (abort || (interval_end && position == goal)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state       <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // NOTE: non-blocking assignments later in the block win, so a step
      // launch here overrides the plain counting done in the case above.
      if (launch) begin
        state    <= HIGH;
        step     <= 1'b1;
        position <= pos_next;
        period   <= ramp_period;
        n        <= ramp_n;
        cnt      <= '0;
      end
    end
  end
endmodule

// File: tb/tb_stepper_axis.sv
// Scoreboard bench for stepper_axis: model-predicted rise/done events checked as they occur.
module tb_stepper_axis;
  import stepper_pkg::*;

  localparam int POS_W    = 16;
  localparam int PERIOD_W = 12;
  localparam int START    = 40;
  localparam int ACCEL    = 10;
  localparam int PULSE    = 3;
  localparam int SETUP_C  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             abort;
  logic             step;
  logic             dir;
  logic             busy;
  logic             done;
  logic [POS_W-1:0] position;

  stepper_axis_if #(.POS_W(POS_W), .PERIOD_W(PERIOD_W)) cmd_if ();

  stepper_axis #(
    .POS_W        (POS_W),
    .PERIOD_W     (PERIOD_W),
    .START_PERIOD (START),
    .ACCEL_DEC    (ACCEL),
    .PULSE_CYC    (PULSE),
    .DIR_SETUP_CYC(SETUP_C)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cmd     (cmd_if),
    .abort   (abort),
    .step    (step),
    .dir     (dir),
    .busy    (busy),
    .done    (done),
    .position(position)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int cyc;
    int pos;
    bit dir;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   model_pos = 0;
  bit   model_dir = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: predicts every rise and the done pulse of one command accepted at t.
  function automatic void model_push(input int t, input int goal, input int per, input int abort_step);
    int tgt, p, n, steps, r, tt;
    bit d;
    tgt = (per < PULSE + 1) ? PULSE + 1 : per;
    if (goal == model_pos) begin
      sb.push_back('{1'b1, t + 1, model_pos, model_dir});
      return;
    end
    d         = (goal < model_pos);
    model_dir = d;
    p         = (tgt > START) ? tgt : START;
    n         = 0;
    steps     = d ? model_pos - goal : goal - model_pos;
    tt        = t + 1 + SETUP_C;
    for (int k = 1; k <= steps; k++) begin
      model_pos = d ? model_pos - 1 : model_pos + 1;
      sb.push_back('{1'b0, tt, model_pos, d});
      r = steps - k;
      if (r <= n) begin
        p = (p + ACCEL > START) ? START : p + ACCEL;
        if (n > 0) n--;
      end else if (p > tgt) begin
        p = (p - ACCEL < tgt) ? tgt : p - ACCEL;
        n++;
      end
      if (k == abort_step) begin
        sb.push_back('{1'b1, tt + PULSE, model_pos, d});
        return;
      end
      if (r == 0) sb.push_back('{1'b1, tt + p, model_pos, d});
      else        tt += p;
    end
  endfunction

  task automatic sb_pop(input bit is_done);
    exp_t e;
    if (sb.size() == 0) begin
      check(is_done ? "unexpected_done" : "unexpected_rise", sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    check(is_done ? "kind_done" : "kind_rise", 32'(is_done), 32'(e.is_done));
    check(is_done ? "done_cycle" : "rise_cycle", cyc, e.cyc);
    check(is_done ? "done_position" : "rise_position", 32'(position), e.pos);
    check(is_done ? "done_dir" : "rise_dir", 32'(dir), 32'(e.dir));
  endtask

  logic step_d   = 1'b0;
  int   high_len = 0;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (step && !step_d) sb_pop(1'b0);
      if (step) begin
        high_len = step_d ? high_len + 1 : 1;
      end else if (step_d) begin
        check("pulse_width", high_len, PULSE);
      end
      if (done) begin
        sb_pop(1'b1);
        check("busy_at_done", 32'(busy), 0);
        check("ready_at_done", 32'(cmd_if.cmd_ready), 0);
      end
    end
    step_d = step;
  end

  task automatic run_move(input int goal, input int per, input int abort_step);
    int   guard;
    int   seen;
    int   start_pos;
    logic prev;
    guard = 0;
    while (cmd_if.cmd_ready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready", 32'(cmd_if.cmd_ready), 1);
    start_pos             = model_pos;
    cmd_if.cmd_valid      = 1'b1;
    cmd_if.cmd_goal       = POS_W'(goal);
    cmd_if.cmd_period     = PERIOD_W'(per);
    model_push(cyc, goal, per, abort_step);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'(goal != start_pos));
    if (goal != start_pos) begin
      check("dir_after_accept", 32'(dir), 32'(goal < start_pos));
      check("step_in_setup", 32'(step), 0);
    end
    if (abort_step > 0) begin
      seen  = 0;
      prev  = step;
      guard = 0;
      while (seen < abort_step && guard < 2000) begin
        @(negedge clk);
        guard++;
        if (step && !prev) seen++;
        prev = step;
      end
      check("abort_reach", seen, abort_step);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    guard = 0;
    while (sb.size() > 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    reset             = 1'b0;
    abort             = 1'b0;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_goal   = POS_W'(3);
    cmd_if.cmd_period = PERIOD_W'(40);
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cmd_if.cmd_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_step", 32'(step), 0);
    check("rst_position", 32'(position), 0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(cmd_if.cmd_ready), 1);
    check("rel_busy", 32'(busy), 0);
    check("rel_done", 32'(done), 0);
    check("rel_step", 32'(step), 0);
    check("rel_dir", 32'(dir), 0);
    check("rel_position", 32'(position), 0);
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);

    run_move(5, 40, 0);   // cruise at start period
    run_move(0, 40, 0);   // back to origin
    run_move(8, 20, 0);   // accelerate, cruise, decelerate
    run_move(5, 40, 0);   // decrement with dir setup
    run_move(0, 40, 0);
    run_move(10, 40, 3);  // abort during third pulse
    run_move(3, 0, 0);    // zero-length move
    run_move(1, 0, 0);    // clamped target period

    repeat (5) @(negedge clk);
    check("final_position", 32'(position), model_pos);
    check("final_idle_busy", 32'(busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
